countdown_timer_ctrl: RTL
=========================

Name: countdown_timer_ctrl

Overview:
- Sequencer for the M:SS time display: loads a BCD time from a keypad, counts down once per second, and drives the three BCD digit buses that feed the 7-segment decoder (Minutos, DezenaSeg, UnidadeSeg).
- Sits between keypad/button debouncers and the display decoder in the timer top level.
- Range 0:00 to 9:59.

Parameters:
- CLK_DIV, 50_000_000, clk cycles per countdown second; must be ≥2. Benches use 4.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe: key_value holds a keypad digit
- key_value  in  4  BCD digit entered
- start  in  1  one-cycle strobe: start or resume countdown
- stop  in  1  one-cycle strobe: pause, or clear when already paused or setting
- Minutos  out  4  BCD minutes digit, 0..9
- DezenaSeg  out  4  BCD seconds tens digit, 0..5
- UnidadeSeg  out  4  BCD seconds units digit, 0..9
- running  out  1  high while in RUNNING
- alarm  out  1  high while in DONE
- done  out  1  one-cycle pulse on the cycle DONE is entered

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all digits 0; running=0; alarm=0; done=0; prescaler=0.
  - Reset asserted mid-count aborts immediately with no done pulse.
- States: IDLE, SETTING, RUNNING, PAUSED, DONE. All outputs are registered.
- Strobe priority when several are high in one cycle: stop > start > key_valid. Only the highest-priority strobe acts.
- Key entry (IDLE or SETTING only; key_valid ignored in RUNNING and PAUSED):
  - key_value > 9 is ignored.
  - An accepted key shifts digits left: Minutos<=DezenaSeg, DezenaSeg<=UnidadeSeg, UnidadeSeg<=key_value.
  - Shift is rejected (no change) if the old UnidadeSeg > 5, because DezenaSeg would become invalid.
  - The old Minutos digit is discarded.
  - IDLE -> SETTING on the first accepted key, including key 0.
- start:
  - In SETTING or PAUSED with time != 0:00 -> RUNNING.
  - Prescaler cleared on SETTING->RUNNING; prescaler retained on PAUSED->RUNNING.
  - Ignored when time is 0:00, and in IDLE or RUNNING.
- RUNNING:
  - Prescaler counts 0..CLK_DIV-1 and wraps.
  - On the cycle the prescaler is at CLK_DIV-1, the BCD time decrements by one second; new digits are visible the next cycle.
  - Borrow rules:
    - UnidadeSeg 0 -> 9 and borrow from DezenaSeg.
    - DezenaSeg 0 -> 5 and borrow from Minutos.
    - Minutos never underflows, because 0:00 exits RUNNING.
  - The decrement that yields 0:00 moves to DONE in the same edge: done=1 for exactly that one cycle, alarm=1, running=0.
  - First decrement lands CLK_DIV cycles after the start strobe cycle.
- stop:
  - RUNNING -> PAUSED: digits and prescaler held.
  - PAUSED or SETTING -> IDLE with digits cleared to 0:00.
  - Ignored in IDLE.
- DONE:
  - Digits hold 0:00; alarm held high.
  - Any of key_valid, start or stop -> IDLE with alarm=0. The strobe is consumed; no digit shift.
- Decrement and stop on the same cycle: stop wins, no decrement, prescaler frozen.
- Illegal/unreachable state encodings recover to IDLE with digits cleared.

Test Plan:
- CLK_DIV=4. Reset, keys 1,3,0 -> digits 1:30, state SETTING; then key 7 -> 3:07, since old UnidadeSeg 0 ≤ 5 lets the shift proceed.
- Load 0:07, then key 8 -> accepted, 0:78? No: old UnidadeSeg=7 > 5, so the shift is rejected and the display stays 0:07. Also key_value=4'hA -> ignored.
- Load 1:00, start -> 4 cycles later 0:59; a further 4 cycles -> 0:58; running=1 throughout.
- Load 0:02, start -> 0:01 after 4 cycles, then 0:00 after 8 cycles with done pulsed exactly 1 cycle, alarm=1, running=0; then start -> IDLE, alarm=0.
- Load 0:10, start; stop 2 cycles in -> PAUSED at 0:10, digits frozen 20 cycles; start -> decrement to 0:09 after 2 more cycles (prescaler retained); stop, stop -> IDLE 0:00.
- Load 0:05, start; assert reset mid-count -> all outputs 0 asynchronously, no done pulse. Separately, start and stop in the same cycle from SETTING -> IDLE, digits cleared.

Source files
------------

// File: rtl/countdown_timer_ctrl.sv
// M:SS countdown sequencer: keypad entry, 1 Hz BCD countdown, pause/resume and alarm.
// Drives the three BCD digit buses of the 7-segment display decoder.
module countdown_timer_ctrl #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] Minutos,
  output logic [3:0] DezenaSeg,
  output logic [3:0] UnidadeSeg,
  output logic       running,
  output logic       alarm,
  output logic       done
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTING = 3'd1,
    RUNNING = 3'd2,
    PAUSED  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [3:0]    min_n, dez_n, uni_n;
  logic [PW-1:0] psc, psc_n;
  logic          done_n;
  logic          time_zero;
  logic          tick;
  logic          key_ok;
  logic [11:0]   dec_time;

  // One-second BCD decrement with borrow; caller guarantees the time is not 0:00.
  function automatic logic [11:0] bcd_dec(input logic [3:0] m, input logic [3:0] t,
                                          input logic [3:0] u);
    if (u != 4'd0)
      return {m, t, u - 4'd1};
    else if (t != 4'd0)
      return {m, t - 4'd1, 4'd9};
    else
      return {m - 4'd1, 4'd5, 4'd9};
  endfunction

  assign time_zero = ({Minutos, DezenaSeg, UnidadeSeg} == 12'd0);
  assign tick      = (psc == PSC_MAX);
  assign dec_time  = bcd_dec(Minutos, DezenaSeg, UnidadeSeg);
  // A units digit above 5 cannot move into the seconds-tens position.
  assign key_ok    = key_valid && (key_value <= 4'd9) && (UnidadeSeg <= 4'd5);

  always_comb begin
    state_n = state;
    min_n   = Minutos;
    dez_n   = DezenaSeg;
    uni_n   = UnidadeSeg;
    psc_n   = psc;
    done_n  = 1'b0;
    case (state)
      IDLE, SETTING: begin
        if (stop) begin
          if (state == SETTING) begin
            state_n = IDLE;
            min_n   = 4'd0;
            dez_n   = 4'd0;
            uni_n   = 4'd0;
          end
        end else if (start) begin
          if (state == SETTING && !time_zero) begin
            state_n = RUNNING;
            psc_n   = '0;
          end
        end else if (key_ok) begin
          state_n = SETTING;
          min_n   = DezenaSeg;
          dez_n   = UnidadeSeg;
          uni_n   = key_value;
        end
      end
      RUNNING: begin
        if (stop) begin
          state_n = PAUSED;
        end else if (tick) begin
          psc_n = '0;
          {min_n, dez_n, uni_n} = dec_time;
          if (dec_time == 12'd0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end else begin
          psc_n = psc + 1'b1;
        end
      end
      PAUSED: begin
        if (stop) begin
          state_n = IDLE;
          min_n   = 4'd0;
          dez_n   = 4'd0;
          uni_n   = 4'd0;
        end else if (start && !time_zero) begin
          state_n = RUNNING;
        end
      end
      DONE: begin
        if (stop || start || key_valid)
          state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        min_n   = 4'd0;
        dez_n   = 4'd0;
        uni_n   = 4'd0;
        psc_n   = '0;
      end
    endcase
  end

  // Flags are registered from the next state so they align with the digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      Minutos    <= 4'd0;
      DezenaSeg  <= 4'd0;
      UnidadeSeg <= 4'd0;
      psc        <= '0;
      running    <= 1'b0;
      alarm      <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      Minutos    <= min_n;
      DezenaSeg  <= dez_n;
      UnidadeSeg <= uni_n;
      psc        <= psc_n;
      running    <= (state_n == RUNNING);
      alarm      <= (state_n == DONE);
      done       <= done_n;
    end
  end

endmodule
